// File: rtl/fpu_result_stage.sv
// Two-entry in-order skid buffer that registers the final FPU result and its exception flags.
// Optional sticky exception accumulation is compiled in with macro FPU_STICKY_FLAGS_EN.
module fpu_result_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sign,
    input  logic [22:0] in_mant,
    input  logic [7:0]  in_exp,
    input  logic        in_inexact,
    input  logic        in_overflow,
    input  logic        in_underflow,
    input  logic        in_invalid,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [3:0]  out_flags,
    input  logic        flags_clear,
    output logic [3:0]  sticky_flags
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]  state_r;
    logic [1:0]  state_nxt_s;
    logic [35:0] head_r;
    logic [35:0] tail_r;
    logic [35:0] head_nxt_s;
    logic [35:0] tail_nxt_s;
    logic [35:0] in_word_s;
    logic        push_s;
    logic        pop_s;

    // Entry layout {invalid, overflow, underflow, inexact, sign, exp, mant}
    assign in_word_s  = {in_invalid, in_overflow, in_underflow, in_inexact, in_sign, in_exp, in_mant};
    assign in_ready   = (state_r != ST_FULL);
    assign out_valid  = (state_r != ST_EMPTY);
    assign push_s     = in_valid & in_ready;
    assign pop_s      = out_valid & out_ready;
    // Vacated slots are zeroed so the head register alone drives zeros when empty
    assign out_result = head_r[31:0];
    assign out_flags  = head_r[35:32];

    // Next-state and entry movement for the two-slot buffer
    always_comb begin
        state_nxt_s = state_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        case (state_r)
            ST_EMPTY: begin
                if (push_s) begin
                    state_nxt_s = ST_ONE;
                    head_nxt_s  = in_word_s;
                end else begin
                    state_nxt_s = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (push_s && pop_s) begin
                    head_nxt_s = in_word_s;
                end else if (push_s) begin
                    state_nxt_s = ST_FULL;
                    tail_nxt_s  = in_word_s;
                end else if (pop_s) begin
                    state_nxt_s = ST_EMPTY;
                    head_nxt_s  = 36'd0;
                end else begin
                    state_nxt_s = ST_ONE;
                end
            end
            ST_FULL: begin
                if (pop_s) begin
                    state_nxt_s = ST_ONE;
                    head_nxt_s  = tail_r;
                    tail_nxt_s  = 36'd0;
                end else begin
                    state_nxt_s = ST_FULL;
                end
            end
            default: begin
                state_nxt_s = ST_EMPTY;
                head_nxt_s  = 36'd0;
                tail_nxt_s  = 36'd0;
            end
        endcase
    end

    // Buffer state and entry registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
            head_r  <= 36'd0;
            tail_r  <= 36'd0;
        end else begin
            state_r <= state_nxt_s;
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
        end
    end

`ifdef FPU_STICKY_FLAGS_EN
    logic [3:0] sticky_r;

    // Accumulate flags of every popped word; a clear still keeps the coincident pop's flags
    always_ff @(posedge clk) begin
        if (rst) begin
            sticky_r <= 4'd0;
        end else begin
            sticky_r <= (flags_clear ? 4'd0 : sticky_r) | (pop_s ? head_r[35:32] : 4'd0);
        end
    end

    assign sticky_flags = sticky_r;
`else
    logic unused_flags_clear_s;

    assign unused_flags_clear_s = flags_clear;
    assign sticky_flags         = 4'd0;
`endif

endmodule

// File: tb/tb_fpu_result_stage.sv
// Randomised self-checking bench for fpu_result_stage against a queue-based reference model.
// Honours FPU_STICKY_FLAGS_EN the same way as the design build.
module tb_fpu_result_stage;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, in_sign;
    logic [22:0] in_mant;
    logic [7:0]  in_exp;
    logic        in_inexact, in_overflow, in_underflow, in_invalid;
    logic        out_valid, out_ready, flags_clear;
    logic [31:0] out_result;
    logic [3:0]  out_flags, sticky_flags;

    logic [35:0] model_q[$];
    logic [3:0]  model_sticky = 4'd0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;

    fpu_result_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_sign(in_sign), .in_mant(in_mant), .in_exp(in_exp),
        .in_inexact(in_inexact), .in_overflow(in_overflow),
        .in_underflow(in_underflow), .in_invalid(in_invalid),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_flags(out_flags), .flags_clear(flags_clear), .sticky_flags(sticky_flags)
    );

    function automatic logic [31:0] exp_result();
        logic [35:0] h;
        if (model_q.size() == 0) return 32'd0;
        h = model_q[0];
        return h[31:0];
    endfunction

    function automatic logic [3:0] exp_flags();
        logic [35:0] h;
        if (model_q.size() == 0) return 4'd0;
        h = model_q[0];
        return h[35:32];
    endfunction

    // One clock: drive at negedge, advance model at posedge, leave time 1 unit after the edge
    task automatic step(input logic r, input logic v, input logic [35:0] w,
                        input logic ordy, input logic clr);
        logic        push, pop;
        logic [35:0] h;
        @(negedge clk);
        rst = r; in_valid = v; out_ready = ordy; flags_clear = clr;
        {in_invalid, in_overflow, in_underflow, in_inexact, in_sign, in_exp, in_mant} = w;
        push = v && (model_q.size() < 2);
        pop  = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (r) begin
            model_q.delete();
            model_sticky = 4'd0;
        end else begin
            if (pop) begin
                h = model_q.pop_front();
`ifdef FPU_STICKY_FLAGS_EN
                model_sticky = (clr ? 4'd0 : model_sticky) | h[35:32];
`endif
            end else begin
`ifdef FPU_STICKY_FLAGS_EN
                if (clr) model_sticky = 4'd0;
`endif
            end
            if (push) model_q.push_back(w);
        end
        #1;
    endtask

    task automatic test_reset();
        step(1'b1, 1'b0, 36'd0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 36'hF_FFFF_FFFF, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b exp 0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        checks++; if (out_result !== 32'd0) begin errors++; $display("FAIL reset_out_result got %h exp 0", out_result); end
        checks++; if ({out_flags, sticky_flags} !== 8'd0) begin errors++; $display("FAIL reset_flags got %h/%h exp 0/0", out_flags, sticky_flags); end
    endtask

    task automatic test_single();
        step(1'b0, 1'b1, {4'd0, 1'b0, 8'h7F, 23'h0}, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h3F80_0000) begin errors++;
            $display("FAIL single_present got v=%b %h exp v=1 3f800000", out_valid, out_result); end
        step(1'b0, 1'b0, 36'd0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0 || out_result !== 32'd0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL single_drain got v=%b r=%b %h exp v=0 r=1 0", out_valid, in_ready, out_result); end
    endtask

    task automatic test_backpressure();
        step(1'b0, 1'b1, {4'd0, 32'h4000_0000}, 1'b0, 1'b0);
        step(1'b0, 1'b1, {4'd0, 32'h4040_0000}, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0 || out_result !== 32'h4000_0000) begin errors++;
            $display("FAIL bp_full got r=%b %h exp r=0 40000000", in_ready, out_result); end
        step(1'b0, 1'b1, {4'hF, 32'h4080_0000}, 1'b0, 1'b0);
        checks++; if (in_ready !== 1'b0 || out_result !== 32'h4000_0000 || out_flags !== 4'd0) begin errors++;
            $display("FAIL bp_hold got r=%b %h f=%h exp r=0 40000000 f=0", in_ready, out_result, out_flags); end
        step(1'b0, 1'b0, 36'd0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_result !== 32'h4040_0000) begin errors++;
            $display("FAIL bp_second got v=%b %h exp v=1 40400000", out_valid, out_result); end
        step(1'b0, 1'b0, 36'd0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0 || out_result !== 32'd0) begin errors++;
            $display("FAIL bp_empty got v=%b %h exp v=0 0", out_valid, out_result); end
    endtask

    task automatic test_back_to_back();
        logic [35:0] words[11];
        for (int i = 0; i < 11; i++) words[i] = {$urandom_range(0, 15), $urandom};
        step(1'b0, 1'b1, words[0], 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(1'b0, 1'b1, words[k + 1], 1'b1, 1'b0);
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || {out_flags, out_result} !== words[k + 1]) begin
                errors++;
                $display("FAIL b2b_word%0d got v=%b r=%b %h exp v=1 r=1 %h", k, out_valid, in_ready,
                         {out_flags, out_result}, words[k + 1]);
            end
        end
        step(1'b0, 1'b0, 36'd0, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got v=%b exp 0", out_valid); end
    endtask

    task automatic test_sticky();
        logic [3:0] exp_a, exp_b;
`ifdef FPU_STICKY_FLAGS_EN
        exp_a = 4'b0101; exp_b = 4'b1000;
`else
        exp_a = 4'b0000; exp_b = 4'b0000;
`endif
        step(1'b1, 1'b0, 36'd0, 1'b0, 1'b0);
        step(1'b0, 1'b1, {4'b0001, 32'h3F80_0001}, 1'b0, 1'b0);
        step(1'b0, 1'b0, 36'd0, 1'b1, 1'b0);
        step(1'b0, 1'b1, {4'b0100, 32'h7F80_0000}, 1'b0, 1'b0);
        step(1'b0, 1'b0, 36'd0, 1'b1, 1'b0);
        checks++; if (sticky_flags !== exp_a || sticky_flags !== model_sticky) begin errors++;
            $display("FAIL sticky_accum got %b exp %b", sticky_flags, exp_a); end
        step(1'b0, 1'b1, {4'b1000, 32'h7FC0_0000}, 1'b0, 1'b0);
        step(1'b0, 1'b0, 36'd0, 1'b1, 1'b1);
        checks++; if (sticky_flags !== exp_b || sticky_flags !== model_sticky) begin errors++;
            $display("FAIL sticky_clear_pop got %b exp %b", sticky_flags, exp_b); end
        step(1'b0, 1'b1, {4'b0010, 32'h0000_0001}, 1'b0, 1'b0);
        step(1'b0, 1'b0, 36'd0, 1'b1, 1'b0);
    endtask

    task automatic test_reset_mid();
        step(1'b0, 1'b1, {4'b1111, 32'h4000_0000}, 1'b0, 1'b0);
        step(1'b0, 1'b1, {4'b0011, 32'h4040_0000}, 1'b0, 1'b0);
        step(1'b1, 1'b1, {4'b0001, 32'h4080_0000}, 1'b1, 1'b0);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++;
            $display("FAIL rstmid_hs got v=%b r=%b exp v=0 r=1", out_valid, in_ready); end
        checks++; if (out_result !== 32'd0 || sticky_flags !== 4'd0 || out_flags !== 4'd0) begin errors++;
            $display("FAIL rstmid_data got %h s=%b f=%b exp 0 0 0", out_result, sticky_flags, out_flags); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 99) == 0), $urandom_range(0, 1) == 1, {$urandom_range(0, 15), $urandom},
                 $urandom_range(0, 9) < 7, $urandom_range(0, 9) == 0);
            checks++;
            if (out_valid !== (model_q.size() > 0) || in_ready !== (model_q.size() < 2) ||
                out_result !== exp_result() || out_flags !== exp_flags() || sticky_flags !== model_sticky) begin
                errors++;
                $display("FAIL random_c%0d got v=%b r=%b %h f=%b s=%b exp v=%b r=%b %h f=%b s=%b", n,
                         out_valid, in_ready, out_result, out_flags, sticky_flags,
                         model_q.size() > 0, model_q.size() < 2, exp_result(), exp_flags(), model_sticky);
            end
        end
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; flags_clear = 1'b0;
        {in_invalid, in_overflow, in_underflow, in_inexact, in_sign, in_exp, in_mant} = 36'd0;
        test_reset();
        test_single();
        test_backpressure();
        test_back_to_back();
        test_sticky();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fpu_result_stage.md
FPU_RESULT_STAGE -- requirements
Module: fpu_result_stage

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1, synchronous reset, active-high.
REQ-003 SHALL have port in_valid, input, 1, upstream result available.
REQ-004 SHALL have port in_ready, output, 1, stage can accept this cycle.
REQ-005 SHALL have port in_sign, input, 1, result sign.
REQ-006 SHALL have port in_mant, input, 23, final mantissa from rounding/final-output stage.
REQ-007 SHALL have port in_exp, input, 8, final biased exponent.
REQ-008 SHALL have ports in_inexact, in_overflow, in_underflow, in_invalid, input, 1 each, per-operation exception flags.
REQ-009 SHALL have port out_valid, output, 1, head entry presented.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts.
REQ-011 SHALL have port out_result, output, 32, packed {sign, exp[7:0], mant[22:0]} of head entry.
REQ-012 SHALL have port out_flags, output, 4, {invalid, overflow, underflow, inexact} of head entry.
REQ-013 SHALL have port flags_clear, input, 1, clears sticky flags.
REQ-014 SHALL have port sticky_flags, output, 4, accumulated flags, same bit order as out_flags.

Function
REQ-015 SHALL implement a 2-entry in-order buffer with states EMPTY, ONE, FULL.
REQ-016 SHALL define push = in_valid & in_ready and pop = out_valid & out_ready.
REQ-017 SHALL drive in_ready = (state != FULL), independent of out_ready in the same cycle.
REQ-018 SHALL drive out_valid = (state != EMPTY).
REQ-019 SHALL register 36 bits per entry: sign, exp, mant, 4 flags; no arithmetic on data.
REQ-020 SHALL present pushed data at outputs no earlier than the cycle after push (latency 1 when EMPTY).
REQ-021 SHALL transition EMPTY->ONE on push; ONE->FULL on push without pop; ONE->EMPTY on pop without push; ONE->ONE on push with pop, head replaced by new word; FULL->ONE on pop, second entry becomes head.
REQ-022 SHALL never drop, duplicate, or reorder words; outputs SHALL stay stable while out_valid & !out_ready.
REQ-023 SHALL ignore in_valid and in_* data when in_ready is 0.
REQ-024 SHALL hold out_result and out_flags at zero when state is EMPTY.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, set state EMPTY, both entries zero, out_valid=0, in_ready=1, out_result=0, out_flags=0, sticky_flags=0.
REQ-026 SHALL discard buffered words on reset mid-operation; push/pop in the reset cycle SHALL have no effect.

Configuration
REQ-027 SHALL compile sticky flag accumulation in only when macro FPU_STICKY_FLAGS_EN is defined.
REQ-028 SHALL, with FPU_STICKY_FLAGS_EN, set sticky_flags <= (flags_clear ? 0 : sticky_flags) | (pop ? head flags : 0) each cycle; a pop coinciding with flags_clear leaves only that pop's flags.
REQ-029 SHALL, without FPU_STICKY_FLAGS_EN, tie sticky_flags to 0 and ignore flags_clear, with no extra state.

Verification
REQ-030 SHALL verify single transfer: after reset push {0, 8'h7F, 23'h0} with out_ready=1 -> next cycle out_valid=1, out_result=32'h3F800000, popped; then EMPTY.
REQ-031 SHALL verify backpressure: out_ready=0, push A=32'h40000000 then B=32'h40400000 -> in_ready=0 in FULL; third in_valid ignored; out_ready=1 -> A then B in order.
REQ-032 SHALL verify simultaneous push/pop in ONE for 10 consecutive words -> state stays ONE, each word emitted exactly once in order, throughput 1/cycle.
REQ-033 SHALL verify sticky flags (macro on): pop word with inexact=1, then word with overflow=1 -> sticky_flags=4'b0101; flags_clear with pop of invalid word -> 4'b1000.
REQ-034 SHALL verify reset mid-operation in FULL -> next cycle out_valid=0, in_ready=1, out_result=0, sticky_flags=0.
REQ-035 SHALL verify macro off: flagged pops and flags_clear -> sticky_flags remains 4'b0000.
